// File: rtl/contador_bcd_3digitos_regressivo.sv
// Three-digit BCD down counter with preset load, per-digit clamping and terminal-count flags.
// WRAP selects whether counting at 000 rolls over to 999 or holds at 000.
module contador_bcd_3digitos_regressivo #(
   parameter bit WRAP = 1'b0
) (
   input  logic       clock,
   input  logic       zera_n,
   input  logic       zera,
   input  logic       carrega,
   input  logic [3:0] valor0,
   input  logic [3:0] valor1,
   input  logic [3:0] valor2,
   input  logic       conta,
   output logic [3:0] digito0,
   output logic [3:0] digito1,
   output logic [3:0] digito2,
   output logic       fim,
   output logic       pulso_fim
);

   logic [3:0] dec0;
   logic [3:0] dec1;
   logic [3:0] dec2;
   logic       borrow0;
   logic       borrow1;
   logic       em_um;
   logic       decrementa;

   // Out-of-range preset nibbles load as 9 so a digit can never leave 0..9.
   function automatic logic [3:0] satura(input logic [3:0] v);
      return (v > 4'd9) ? 4'd9 : v;
   endfunction

   // Borrow ripples units -> tens -> hundreds; at 000 this naturally yields 999.
   always_comb begin
      borrow0 = (digito0 == 4'd0);
      dec0    = borrow0 ? 4'd9 : 4'(digito0 - 4'd1);
      borrow1 = borrow0 && (digito1 == 4'd0);
      dec1    = digito1;
      if (borrow0) begin
         dec1 = (digito1 == 4'd0) ? 4'd9 : 4'(digito1 - 4'd1);
      end
      dec2 = digito2;
      if (borrow1) begin
         dec2 = (digito2 == 4'd0) ? 4'd9 : 4'(digito2 - 4'd1);
      end
   end

   assign fim        = (digito2 == 4'd0) && (digito1 == 4'd0) && (digito0 == 4'd0);
   assign em_um      = (digito2 == 4'd0) && (digito1 == 4'd0) && (digito0 == 4'd1);
   assign decrementa = conta && (!fim || WRAP);

   // Priority: zera, then carrega, then conta; pulso_fim only fires on the 001 -> 000 step.
   always_ff @(posedge clock or negedge zera_n) begin
      if (!zera_n) begin
         digito0   <= 4'd0;
         digito1   <= 4'd0;
         digito2   <= 4'd0;
         pulso_fim <= 1'b0;
      end else if (zera) begin
         digito0   <= 4'd0;
         digito1   <= 4'd0;
         digito2   <= 4'd0;
         pulso_fim <= 1'b0;
      end else if (carrega) begin
         digito0   <= satura(valor0);
         digito1   <= satura(valor1);
         digito2   <= satura(valor2);
         pulso_fim <= 1'b0;
      end else if (decrementa) begin
         digito0   <= dec0;
         digito1   <= dec1;
         digito2   <= dec2;
         pulso_fim <= em_um;
      end else begin
         pulso_fim <= 1'b0;
      end
   end

endmodule

// File: tb/tb_contador_bcd_3digitos_regressivo.sv
// Bench for the BCD down counter: a WRAP=0 and a WRAP=1 instance share stimulus and are
// compared every cycle against an integer-valued model, with literal spot checks.
module tb_contador_bcd_3digitos_regressivo;

   logic       clock = 1'b0;
   logic       zera_n;
   logic       zera;
   logic       carrega;
   logic       conta;
   logic [3:0] valor0;
   logic [3:0] valor1;
   logic [3:0] valor2;

   logic [3:0] h0d0, h0d1, h0d2, w1d0, w1d1, w1d2;
   logic       h0fim, h0pulso, w1fim, w1pulso;

   int total = 0;
   int bad = 0;
   bit checkEn = 1'b0;

   int valH = 0;
   int valW = 0;
   bit pulH = 1'b0;
   bit pulW = 1'b0;

   always #5 clock = ~clock;

   contador_bcd_3digitos_regressivo #(.WRAP(1'b0)) dutHold (
      .clock(clock), .zera_n(zera_n), .zera(zera), .carrega(carrega),
      .valor0(valor0), .valor1(valor1), .valor2(valor2), .conta(conta),
      .digito0(h0d0), .digito1(h0d1), .digito2(h0d2), .fim(h0fim), .pulso_fim(h0pulso)
   );

   contador_bcd_3digitos_regressivo #(.WRAP(1'b1)) dutWrap (
      .clock(clock), .zera_n(zera_n), .zera(zera), .carrega(carrega),
      .valor0(valor0), .valor1(valor1), .valor2(valor2), .conta(conta),
      .digito0(w1d0), .digito1(w1d1), .digito2(w1d2), .fim(w1fim), .pulso_fim(w1pulso)
   );

   function automatic int clampDigit(input logic [3:0] v);
      return (v > 4'd9) ? 9 : int'(v);
   endfunction

   // Model holds the count as a plain integer 0..999.
   always @(posedge clock or negedge zera_n) begin
      if (!zera_n) begin
         valH <= 0; valW <= 0; pulH <= 1'b0; pulW <= 1'b0;
      end else if (zera) begin
         valH <= 0; valW <= 0; pulH <= 1'b0; pulW <= 1'b0;
      end else if (carrega) begin
         valH <= clampDigit(valor2) * 100 + clampDigit(valor1) * 10 + clampDigit(valor0);
         valW <= clampDigit(valor2) * 100 + clampDigit(valor1) * 10 + clampDigit(valor0);
         pulH <= 1'b0; pulW <= 1'b0;
      end else if (conta) begin
         valH <= (valH == 0) ? 0 : valH - 1;
         pulH <= (valH == 1);
         valW <= (valW == 0) ? 999 : valW - 1;
         pulW <= (valW == 1);
      end else begin
         pulH <= 1'b0; pulW <= 1'b0;
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic int asValue(input logic [3:0] d2, input logic [3:0] d1, input logic [3:0] d0);
      return int'(d2) * 100 + int'(d1) * 10 + int'(d0);
   endfunction

   always @(negedge clock) begin
      if (checkEn) begin
         checkOutput("hold digitos", asValue(h0d2, h0d1, h0d0), valH);
         checkOutput("hold fim", int'(h0fim), int'(valH == 0));
         checkOutput("hold pulso", int'(h0pulso), int'(pulH));
         checkOutput("wrap digitos", asValue(w1d2, w1d1, w1d0), valW);
         checkOutput("wrap fim", int'(w1fim), int'(valW == 0));
         checkOutput("wrap pulso", int'(w1pulso), int'(pulW));
      end
   end

   task automatic applyStimulus(input logic z, input logic c, input logic ct,
                                input logic [3:0] v2, input logic [3:0] v1, input logic [3:0] v0);
      zera = z; carrega = c; conta = ct;
      valor2 = v2; valor1 = v1; valor0 = v0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   initial begin
      zera_n = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
      #2;
      checkOutput("reset digitos", asValue(h0d2, h0d1, h0d0), 0);
      checkOutput("reset fim", int'(h0fim), 1);
      checkOutput("reset pulso", int'(h0pulso), 0);

      @(negedge clock);
      checkEn = 1'b1;
      zera_n  = 1'b1;
      tick(2);
      checkOutput("release idle", asValue(h0d2, h0d1, h0d0), 0);

      // Full countdown from 123
      applyStimulus(1'b0, 1'b1, 1'b0, 4'd1, 4'd2, 4'd3);
      tick(1);
      checkOutput("load 123", asValue(h0d2, h0d1, h0d0), 123);
      applyStimulus(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0);
      tick(122);
      checkOutput("before end", asValue(h0d2, h0d1, h0d0), 1);
      checkOutput("before end fim", int'(h0fim), 0);
      tick(1);
      checkOutput("end digitos", asValue(h0d2, h0d1, h0d0), 0);
      checkOutput("end pulso", int'(h0pulso), 1);
      checkOutput("end wrap pulso", int'(w1pulso), 1);
      tick(10);
      checkOutput("hold at 000", asValue(h0d2, h0d1, h0d0), 0);
      checkOutput("hold no pulse", int'(h0pulso), 0);

      // Borrow chains
      applyStimulus(1'b0, 1'b1, 1'b0, 4'd1, 4'd0, 4'd0);
      tick(1);
      applyStimulus(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0);
      tick(1);
      checkOutput("100 -> 099", asValue(h0d2, h0d1, h0d0), 99);
      applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 4'd1, 4'd0);
      tick(1);
      applyStimulus(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0);
      tick(1);
      checkOutput("010 -> 009", asValue(h0d2, h0d1, h0d0), 9);
      applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
      tick(1);
      checkOutput("load 000 fim", int'(h0fim), 1);
      checkOutput("load 000 pulso", int'(h0pulso), 0);

      // Wrap behaviour
      applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd1);
      tick(1);
      applyStimulus(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0);
      tick(1);
      checkOutput("wrap 001->000 pulso", int'(w1pulso), 1);
      tick(1);
      checkOutput("wrap to 999", asValue(w1d2, w1d1, w1d0), 999);
      checkOutput("wrap 999 fim", int'(w1fim), 0);
      checkOutput("wrap 999 pulso", int'(w1pulso), 0);
      tick(999);
      checkOutput("wrap back 000", asValue(w1d2, w1d1, w1d0), 0);
      checkOutput("wrap back pulso", int'(w1pulso), 1);

      // Priority and clamping
      applyStimulus(1'b0, 1'b1, 1'b1, 4'hC, 4'hA, 4'hF);
      tick(1);
      checkOutput("clamp load 999", asValue(h0d2, h0d1, h0d0), 999);
      applyStimulus(1'b1, 1'b1, 1'b1, 4'd5, 4'd5, 4'd5);
      tick(1);
      checkOutput("zera wins", asValue(h0d2, h0d1, h0d0), 0);

      // Asynchronous reset in the middle of a count
      applyStimulus(1'b0, 1'b1, 1'b0, 4'd5, 4'd0, 4'd0);
      tick(1);
      applyStimulus(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0);
      tick(37);
      checkOutput("count 463", asValue(h0d2, h0d1, h0d0), 463);
      #2 zera_n = 1'b0;
      #1;
      checkOutput("async digitos", asValue(h0d2, h0d1, h0d0), 0);
      checkOutput("async fim", int'(h0fim), 1);
      checkOutput("async wrap digitos", asValue(w1d2, w1d1, w1d0), 0);
      @(negedge clock);
      zera_n = 1'b1;
      tick(3);
      checkOutput("post reset hold", asValue(h0d2, h0d1, h0d0), 0);
      checkOutput("post reset no pulse", int'(h0pulso), 0);
      checkOutput("post reset wrap", asValue(w1d2, w1d1, w1d0), 997);

      applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
      tick(2);
      checkEn = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/contador_bcd_3digitos_regressivo.md
Name: contador_bcd_3digitos_regressivo

Overview:
- 3-digit BCD down counter (999..000), loadable, with terminal-count detection.
- Counterpart of the up-counting 3-digit BCD counter. Used for countdown timers and remaining-event counts in the lab designs.
- Loaded with a BCD preset, decrements once per enabled clock, flags arrival at 000.

Parameters:
- WRAP, 0, 1: conta at 000 wraps to 999; 0: counter holds at 000.

Ports:
- clock  input  1  system clock, rising-edge active
- zera_n  input  1  asynchronous active-low reset
- zera  input  1  synchronous clear to 000, active-high
- carrega  input  1  synchronous load of valor2..valor0, active-high
- valor0  input  4  BCD preset, units
- valor1  input  4  BCD preset, tens
- valor2  input  4  BCD preset, hundreds
- conta  input  1  decrement enable, active-high
- digito0  output  4  units digit
- digito1  output  4  tens digit
- digito2  output  4  hundreds digit
- fim  output  1  level, high while count == 000
- pulso_fim  output  1  one-cycle pulse on reaching 000 by counting

Behaviour:
- Clock and reset: one clock domain, reset is asynchronous and active-low (zera_n).
- While zera_n = 0:
  - digito2..0 = 0,0,0
  - pulso_fim = 0
  - fim = 1
- All other updates occur on the rising edge of clock. Priority per edge: zera > carrega > conta > hold.
- zera: digits become 000; pulso_fim = 0 next cycle.
- carrega: each digit takes its valor input. Any valor > 9 is clamped to 9 per digit (e.g. valor = F,A,3 loads 9,9,3). Loading 000 does not assert pulso_fim.
- conta, count != 000: BCD decrement.
  - digito0 decrements; if digito0 == 0 it becomes 9 and borrows.
  - A borrow decrements digito1 with the same rule, then digito2.
  - Examples: 100 -> 099, 010 -> 009, 001 -> 000.
- conta, count == 000:
  - WRAP = 1: next value is 999.
  - WRAP = 0: holds at 000.
  - pulso_fim is not asserted in either case.
- fim: combinational from the digit registers (digito2 == 0 and digito1 == 0 and digito0 == 0). No latency relative to the digits.
- pulso_fim: registered. High for exactly the one cycle in which the digits first show 000 after a conta decrement from 001; low otherwise. Repeated conta while at 000 with WRAP = 0 gives no further pulses.
- No conta: digits hold. conta ignored on cycles where zera or carrega is high.
- Digits never leave the 0..9 range under any input sequence.
- Reset mid-count: asserting zera_n asynchronously forces 000 immediately. Counting resumes on the first edge after release with conta = 1 (at 000: wrap or hold per WRAP).

Test Plan:
- Reset: zera_n = 0 -> digits 000, fim = 1, pulso_fim = 0 with no clock edge needed. Release with conta = 0 -> outputs unchanged.
- Full countdown: carrega with valor = 1,2,3, then conta = 1 for 123 cycles.
  - digits reach 000 exactly on the 123rd edge.
  - pulso_fim high that single cycle, fim high from then on.
  - WRAP = 0: remains 000 for 10 further cycles with no pulse.
- Borrow chain: load 100, one conta -> 099; load 010, one conta -> 009; load 000 -> fim = 1, pulso_fim = 0.
- Wrap: WRAP = 1, load 001, conta 2 cycles -> 000 (pulse), then 999 (fim = 0, no pulse). 999 more cycles -> 000 with pulse.
- Priority and clamping:
  - carrega and conta together with valor = C,A,F -> 999 (load wins, clamped).
  - zera with carrega and conta -> 000.
- Async reset mid-count: load 500, count 37 cycles (463), pulse zera_n low between edges -> 000 immediately. Release with conta = 1 and WRAP = 0 -> holds 000.
